// File: rtl/romulator_pkg.sv
// Shared types and constants for the romulator configuration path.
package romulator_pkg;

    localparam int unsigned CONFIG_BITS = 4;

    localparam logic [15:0] DEFAULT_CFG_ADDR = 16'hFFF0;
    localparam logic [7:0]  DEFAULT_KEY1     = 8'hA5;
    localparam logic [7:0]  DEFAULT_KEY2     = 8'h5A;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_KEY1_OK,
        ST_KEY2_OK,
        ST_HOLD
    } state_e;

    // One captured 6502 bus cycle
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rwbar;
    } bus_cap_t;

endpackage

// File: rtl/bus_event_sync.sv
// Brings the asynchronous 6502 bus into the fpga_clk domain and reduces each
// phi2 cycle to a bus_ev pulse plus a wr_ev pulse for writes to CFG_ADDR.
module bus_event_sync
    import romulator_pkg::*;
#(
    parameter logic [15:0] CFG_ADDR = DEFAULT_CFG_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] address_i,
    input  logic [7:0]  data_i,
    input  logic        phi2_i,
    input  logic        rwbar_i,
    output logic        wr_ev_o,
    output logic        bus_ev_o,
    output logic [7:0]  data_o
);

    logic     phi2_s1_q, phi2_s2_q, phi2_prev_q;
    bus_cap_t cap_q, cap_d;
    logic     wr_ev_q, wr_ev_d;
    logic     bus_ev_q, bus_ev_d;
    logic     fall_c;

    // The bus is sampled while synchronised phi2 is high, so the final sample
    // is taken on the same edge at which the falling edge becomes visible.
    always_comb begin
        cap_d    = cap_q;
        fall_c   = phi2_prev_q & ~phi2_s2_q;
        bus_ev_d = fall_c;
        wr_ev_d  = fall_c & ~cap_q.rwbar & (cap_q.addr == CFG_ADDR);
        if (phi2_s2_q) begin
            cap_d = '{addr: address_i, data: data_i, rwbar: rwbar_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phi2_s1_q   <= 1'b0;
            phi2_s2_q   <= 1'b0;
            phi2_prev_q <= 1'b0;
            cap_q       <= '{addr: 16'h0000, data: 8'h00, rwbar: 1'b1};
            wr_ev_q     <= 1'b0;
            bus_ev_q    <= 1'b0;
        end else begin
            phi2_s1_q   <= phi2_i;
            phi2_s2_q   <= phi2_s1_q;
            phi2_prev_q <= phi2_s2_q;
            cap_q       <= cap_d;
            wr_ev_q     <= wr_ev_d;
            bus_ev_q    <= bus_ev_d;
        end
    end

    assign wr_ev_o  = wr_ev_q;
    assign bus_ev_o = bus_ev_q;
    assign data_o   = cap_q.data;

endmodule

// File: rtl/config_switcher.sv
// Owns the enable-table configuration word and the CPU reset; software changes
// it via writes to CFG_ADDR. Define CONFIG_UNLOCK_EN to require the KEY1/KEY2 unlock.
module config_switcher
    import romulator_pkg::*;
#(
    parameter logic [15:0] CFG_ADDR          = DEFAULT_CFG_ADDR,
    parameter logic [7:0]  KEY1              = DEFAULT_KEY1,
    parameter logic [7:0]  KEY2              = DEFAULT_KEY2,
    parameter int unsigned RESET_HOLD_CYCLES = 64,
    parameter int unsigned UNLOCK_TIMEOUT    = 16
) (
    input  logic                   fpga_clk,
    input  logic                   reset,
    input  logic [15:0]            address,
    input  logic [7:0]             data,
    input  logic                   phi2,
    input  logic                   rwbar,
    input  logic [CONFIG_BITS-1:0] default_config,
    output logic [CONFIG_BITS-1:0] configuration,
    output logic                   config_valid,
    output logic                   resetb_out
);

    localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

    logic       wr_ev;
    logic       bus_ev;
    logic [7:0] ev_data;

    bus_event_sync #(
        .CFG_ADDR (CFG_ADDR)
    ) u_bus_event_sync (
        .clk_i     (fpga_clk),
        .rst_i     (reset),
        .address_i (address),
        .data_i    (data),
        .phi2_i    (phi2),
        .rwbar_i   (rwbar),
        .wr_ev_o   (wr_ev),
        .bus_ev_o  (bus_ev),
        .data_o    (ev_data)
    );

    state_e                 state_q, state_d;
    logic [CONFIG_BITS-1:0] cfg_q, cfg_d;
    logic                   valid_q, valid_d;
    logic                   resetb_q, resetb_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   value_ok_c;

    assign value_ok_c = (ev_data[7:CONFIG_BITS] == '0);

`ifdef CONFIG_UNLOCK_EN
    localparam int unsigned TMO_W = $clog2(UNLOCK_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_c;
    assign unused_c = ^{KEY1, KEY2, bus_ev, 32'(UNLOCK_TIMEOUT)};
`endif

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        valid_d  = valid_q;
        resetb_d = resetb_q;
        hold_d   = hold_q;
`ifdef CONFIG_UNLOCK_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            ST_BOOT: begin
                cfg_d    = default_config;
                valid_d  = 1'b1;
                resetb_d = 1'b0;
                hold_d   = HOLD_W'(RESET_HOLD_CYCLES);
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                resetb_d = 1'b0;
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end
                if (hold_q <= HOLD_W'(1)) begin
                    resetb_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
`ifdef CONFIG_UNLOCK_EN
            ST_IDLE: begin
                if (wr_ev && (ev_data == KEY1)) begin
                    tmo_d   = '0;
                    state_d = ST_KEY1_OK;
                end
            end
            ST_KEY1_OK: begin
                // A write wins over a timeout expiring in the same cycle
                if (wr_ev) begin
                    if (ev_data == KEY2) begin
                        tmo_d   = '0;
                        state_d = ST_KEY2_OK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q >= TMO_W'(UNLOCK_TIMEOUT)) begin
                    state_d = ST_IDLE;
                end else if (bus_ev) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_KEY2_OK: begin
                if (wr_ev) begin
                    state_d = ST_IDLE;
                    if (value_ok_c) begin
                        cfg_d    = ev_data[CONFIG_BITS-1:0];
                        resetb_d = 1'b0;
                        hold_d   = HOLD_W'(RESET_HOLD_CYCLES);
                        state_d  = ST_HOLD;
                    end
                end else if (tmo_q >= TMO_W'(UNLOCK_TIMEOUT)) begin
                    state_d = ST_IDLE;
                end else if (bus_ev) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`else
            ST_IDLE: begin
                if (wr_ev && value_ok_c) begin
                    cfg_d    = ev_data[CONFIG_BITS-1:0];
                    resetb_d = 1'b0;
                    hold_d   = HOLD_W'(RESET_HOLD_CYCLES);
                    state_d  = ST_HOLD;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_BOOT;
            cfg_q    <= '0;
            valid_q  <= 1'b0;
            resetb_q <= 1'b0;
            hold_q   <= '0;
`ifdef CONFIG_UNLOCK_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            valid_q  <= valid_d;
            resetb_q <= resetb_d;
            hold_q   <= hold_d;
`ifdef CONFIG_UNLOCK_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign configuration = cfg_q;
    assign config_valid  = valid_q;
    assign resetb_out    = resetb_q;

endmodule

// File: tb/tb_config_switcher.sv
// Self-checking bench for config_switcher: directed and random 6502 bus cycles
// against a sequence-level model of the configuration-change rules.
module tb_config_switcher;

    localparam int unsigned HOLD = 64;
    localparam int unsigned TMO  = 16;
    localparam logic [15:0] CFG  = 16'hFFF0;

    logic        fpga_clk = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] address  = 16'h0000;
    logic [7:0]  data     = 8'h00;
    logic        phi2     = 1'b0;
    logic        rwbar    = 1'b1;
    logic [3:0]  default_config = 4'h7;
    logic [3:0]  configuration;
    logic        config_valid;
    logic        resetb_out;

    config_switcher #(
        .CFG_ADDR          (CFG),
        .KEY1              (8'hA5),
        .KEY2              (8'h5A),
        .RESET_HOLD_CYCLES (HOLD),
        .UNLOCK_TIMEOUT    (TMO)
    ) dut (
        .fpga_clk       (fpga_clk),
        .reset          (reset),
        .address        (address),
        .data           (data),
        .phi2           (phi2),
        .rwbar          (rwbar),
        .default_config (default_config),
        .configuration  (configuration),
        .config_valid   (config_valid),
        .resetb_out     (resetb_out)
    );

    always #5 fpga_clk = ~fpga_clk;

    int tests = 0;
    int fails = 0;
    int ncyc  = 0;

    // Reference model: current value and unlock progress (writes seen so far)
    logic [3:0] m_cfg  = 4'h0;
    int         m_step = 0;
    int         m_idle = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_bus(input logic [15:0] a, input logic [7:0] d, input logic rw,
                             output logic sw, output logic [3:0] nv);
        bit cfg_wr;
        sw     = 1'b0;
        nv     = m_cfg;
        cfg_wr = (rw == 1'b0) && (a == CFG);
`ifdef CONFIG_UNLOCK_EN
        if (cfg_wr) begin
            if (m_step == 0) begin
                if (d == 8'hA5) begin m_step = 1; m_idle = 0; end
            end else if (m_step == 1) begin
                if (d == 8'h5A) begin m_step = 2; m_idle = 0; end
                else m_step = 0;
            end else begin
                m_step = 0;
                if (d < 8'd16) begin sw = 1'b1; nv = d[3:0]; end
            end
        end else if (m_step != 0) begin
            m_idle++;
            if (m_idle >= TMO) m_step = 0;
        end
`else
        if (cfg_wr && d < 8'd16) begin sw = 1'b1; nv = d[3:0]; end
`endif
        m_cfg = nv;
    endtask

    // One phi2 cycle; phi2 falls 1 ns after an edge so latency is exact.
    // abort > 0 asserts reset that many cycles into a resulting hold.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                             input int abort);
        logic       sw;
        logic [3:0] old_cfg, nv;
        string      tag;
        ncyc++;
        tag     = $sformatf("cyc%0d a=%h d=%h rw=%0d", ncyc, a, d, rw);
        old_cfg = m_cfg;
        model_bus(a, d, rw, sw, nv);
        @(posedge fpga_clk); #1;
        address = a; data = d; rwbar = rw; phi2 = 1'b1;
        repeat ($urandom_range(3, 6)) @(posedge fpga_clk);
        #1 phi2 = 1'b0;
        repeat (3) @(posedge fpga_clk);
        #1;
        chk({tag, " cfg_before"}, 32'(configuration), 32'(old_cfg));
        address = 16'h0200 + 16'($urandom_range(0, 255));
        data    = 8'($urandom);
        rwbar   = 1'b1;
        @(posedge fpga_clk); #1;
        chk({tag, " cfg_after"}, 32'(configuration), 32'(nv));
        chk({tag, " resetb"}, 32'(resetb_out), 32'(!sw));
        if (sw && abort > 0) begin
            repeat (abort) @(posedge fpga_clk);
            #2 reset = 1'b1;
            #1;
            chk({tag, " abort cfg"}, 32'(configuration), 32'h0);
            chk({tag, " abort valid"}, 32'(config_valid), 32'h0);
            chk({tag, " abort resetb"}, 32'(resetb_out), 32'h0);
        end else begin
            if (sw) begin
                repeat (HOLD - 1) @(posedge fpga_clk);
                #1 chk({tag, " hold_last_low"}, 32'(resetb_out), 32'h0);
                @(posedge fpga_clk);
                #1 chk({tag, " hold_release"}, 32'(resetb_out), 32'h1);
            end
            repeat ($urandom_range(0, 3)) @(posedge fpga_clk);
        end
    endtask

    task automatic do_reset(input logic [3:0] dflt);
        reset = 1'b1; phi2 = 1'b0; rwbar = 1'b1;
        default_config = dflt;
        @(negedge fpga_clk);
        chk("rst cfg", 32'(configuration), 32'h0);
        chk("rst valid", 32'(config_valid), 32'h0);
        chk("rst resetb", 32'(resetb_out), 32'h0);
        reset  = 1'b0;
        m_cfg  = dflt;
        m_step = 0;
        m_idle = 0;
        @(posedge fpga_clk); #1;
        chk("boot cfg", 32'(configuration), 32'(dflt));
        chk("boot valid", 32'(config_valid), 32'h1);
        chk("boot resetb", 32'(resetb_out), 32'h0);
        repeat (HOLD - 2) @(posedge fpga_clk);
        #1 chk("boot resetb_still_low", 32'(resetb_out), 32'h0);
        @(posedge fpga_clk);
        #1 chk("boot resetb_last_low", 32'(resetb_out), 32'h0);
        @(posedge fpga_clk);
        #1 chk("boot resetb_high", 32'(resetb_out), 32'h1);
    endtask

    task automatic switch_to(input logic [7:0] v, input int abort);
`ifdef CONFIG_UNLOCK_EN
        bus_cycle(CFG, 8'hA5, 1'b0, 0);
        bus_cycle(CFG, 8'h5A, 1'b0, 0);
`endif
        bus_cycle(CFG, v, 1'b0, abort);
    endtask

    task automatic other_cycle();
        logic [15:0] a;
        a = 16'($urandom);
        if (a == CFG) a = 16'h1234;
        bus_cycle(a, 8'($urandom), 1'($urandom), 0);
    endtask

    task automatic rand_cycle();
        int          kind;
        logic [7:0]  d;
        kind = $urandom_range(0, 9);
        case ($urandom_range(0, 3))
            0:       d = 8'hA5;
            1:       d = 8'h5A;
            2:       d = 8'($urandom_range(0, 15));
            default: d = 8'($urandom);
        endcase
        if (kind <= 3)      bus_cycle(CFG, d, 1'b0, 0);
        else if (kind <= 5) bus_cycle(CFG, d, 1'b1, 0);
        else                other_cycle();
    endtask

    initial begin
        #2;
        do_reset(4'h7);
        switch_to(8'h03, 0);
        switch_to(8'h03, 0);
`ifdef CONFIG_UNLOCK_EN
        bus_cycle(CFG, 8'hA5, 1'b0, 0);
        bus_cycle(CFG, 8'h11, 1'b0, 0);
        bus_cycle(CFG, 8'h5A, 1'b0, 0);
        bus_cycle(CFG, 8'h03, 1'b0, 0);
        bus_cycle(CFG, 8'hA5, 1'b0, 0);
        repeat (TMO) other_cycle();
        bus_cycle(CFG, 8'h5A, 1'b0, 0);
        bus_cycle(CFG, 8'h03, 1'b0, 0);
        bus_cycle(CFG, 8'hA5, 1'b0, 0);
        repeat (TMO - 1) other_cycle();
        bus_cycle(CFG, 8'h5A, 1'b0, 0);
        bus_cycle(CFG, 8'h09, 1'b0, 0);
        switch_to(8'h83, 0);
        bus_cycle(CFG, 8'hA5, 1'b0, 0);
        bus_cycle(CFG, 8'h5A, 1'b1, 0);
        bus_cycle(CFG, 8'h04, 1'b0, 0);
`else
        bus_cycle(CFG, 8'h83, 1'b0, 0);
        bus_cycle(CFG, 8'h05, 1'b1, 0);
        bus_cycle(16'hFFF1, 8'h05, 1'b0, 0);
        bus_cycle(CFG, 8'h05, 1'b0, 0);
        bus_cycle(CFG, 8'hA5, 1'b0, 0);
`endif
        repeat (60) rand_cycle();
        switch_to(8'h03, 10);
        do_reset(4'hC);
        switch_to(8'h09, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
